// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder: per-beat LOA/truncate modes on the low K bits,
// elastic valid/ready pipe with an exact shadow sum feeding a saturating error monitor.
module approx_add_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ERRW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W:0]      O,
  input  logic            clr_stats,
  output logic [ERRW-1:0] err_cnt,
  output logic [ERRW-1:0] err_sum,
  output logic [W:0]      err_max
);

  localparam int unsigned CW = W / STAGES;
  localparam int unsigned SW = ((ERRW > W + 1) ? ERRW : W + 1) + 1;

  // Level 0 holds raw operands; level s+1 holds the result of adding chunk s.
  logic [STAGES:0] r_v;
  logic [W-1:0]    r_a    [0:STAGES-1];
  logic [W-1:0]    r_b    [0:STAGES-1];
  logic [1:0]      r_mode [0:STAGES-1];
  logic [W-1:0]    r_sum  [1:STAGES];
  logic [W-1:0]    r_esum [1:STAGES];
  logic [STAGES:1] r_c;
  logic [STAGES:1] r_ec;

  logic [W-1:0]    w_nsum  [1:STAGES];
  logic [W-1:0]    w_nesum [1:STAGES];
  logic [STAGES:1] w_nc;
  logic [STAGES:1] w_nec;
  logic [STAGES:0] w_adv;
  logic            w_room0;
  logic            w_in_fire;

  logic [ERRW-1:0] r_err_cnt;
  logic [ERRW-1:0] r_err_sum;
  logic [W:0]      r_err_max;
  logic [W:0]      w_o;
  logic [W:0]      w_e;
  logic [W:0]      w_d;
  logic [SW-1:0]   w_sum_ext;

  // Ripple-adds one chunk; bits below K in an approximate mode bypass the carry chain
  // and the only carry leaving the approximate region is the LOA carry at bit K-1.
  function automatic logic [CW:0] add_chunk(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b,
    input logic          cin,
    input logic [1:0]    md,
    input int unsigned   base
  );
    logic          c;
    logic [CW-1:0] s;
    c = cin;
    s = '0;
    for (int unsigned j = 0; j < CW; j++) begin
      if ((base + j < K) && (md != 2'd0)) begin
        s[j] = (md == 2'd2) ? 1'b0 : (a[j] | b[j]);
        c    = ((md == 2'd1) && (base + j == K - 1)) ? (a[j] & b[j]) : 1'b0;
      end else begin
        s[j] = a[j] ^ b[j] ^ c;
        c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    return {c, s};
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [W-1:0] MASK = W'({CW{1'b1}}) << (s * CW);
    logic         w_cin;
    logic         w_ecin;
    logic [W-1:0] w_psum;
    logic [W-1:0] w_pesum;
    logic [CW:0]  w_ap;
    logic [CW:0]  w_ex;

    if (s == 0) begin : g_first
      assign w_cin   = 1'b0;
      assign w_ecin  = 1'b0;
      assign w_psum  = '0;
      assign w_pesum = '0;
    end else begin : g_rest
      assign w_cin   = r_c[s];
      assign w_ecin  = r_ec[s];
      assign w_psum  = r_sum[s];
      assign w_pesum = r_esum[s];
    end

    assign w_ap = add_chunk(r_a[s][s*CW +: CW], r_b[s][s*CW +: CW], w_cin, r_mode[s], s * CW);
    assign w_ex = add_chunk(r_a[s][s*CW +: CW], r_b[s][s*CW +: CW], w_ecin, 2'd0, s * CW);

    assign w_nsum[s+1]  = (w_psum & ~MASK) | (W'(w_ap[CW-1:0]) << (s * CW));
    assign w_nesum[s+1] = (w_pesum & ~MASK) | (W'(w_ex[CW-1:0]) << (s * CW));
    assign w_nc[s+1]    = w_ap[CW];
    assign w_nec[s+1]   = w_ex[CW];
  end

  // Walk from the output back: a level may advance when the level after it has room.
  always_comb begin
    logic room;
    w_adv = '0;
    room  = out_ready;
    for (int unsigned i = 0; i <= STAGES; i++) begin
      w_adv[STAGES-i] = r_v[STAGES-i] & room;
      room            = ~r_v[STAGES-i] | room;
    end
    w_room0 = room;
  end

  assign w_in_fire = in_valid & w_room0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_c  <= '0;
      r_ec <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_a[s]    <= '0;
        r_b[s]    <= '0;
        r_mode[s] <= '0;
      end
      for (int unsigned s = 1; s <= STAGES; s++) begin
        r_sum[s]  <= '0;
        r_esum[s] <= '0;
      end
    end else begin
      r_v[0] <= w_in_fire | (r_v[0] & ~w_adv[0]);
      if (w_in_fire) begin
        r_a[0]    <= A;
        r_b[0]    <= B;
        r_mode[0] <= mode;
      end
      for (int unsigned s = 1; s <= STAGES; s++) begin
        r_v[s] <= w_adv[s-1] | (r_v[s] & ~w_adv[s]);
        if (w_adv[s-1]) begin
          r_sum[s]  <= w_nsum[s];
          r_esum[s] <= w_nesum[s];
          r_c[s]    <= w_nc[s];
          r_ec[s]   <= w_nec[s];
        end
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        if (w_adv[s-1]) begin
          r_a[s]    <= r_a[s-1];
          r_b[s]    <= r_b[s-1];
          r_mode[s] <= r_mode[s-1];
        end
      end
    end
  end

  assign w_o       = {r_c[STAGES], r_sum[STAGES]};
  assign w_e       = {r_ec[STAGES], r_esum[STAGES]};
  assign w_d       = (w_e >= w_o) ? (w_e - w_o) : (w_o - w_e);
  assign w_sum_ext = SW'(r_err_sum) + SW'(w_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (clr_stats) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_adv[STAGES]) begin
      if ((w_d != '0) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERRW'(1);
      r_err_sum <= (w_sum_ext > SW'({ERRW{1'b1}})) ? '1 : w_sum_ext[ERRW-1:0];
      if (w_d > r_err_max)
        r_err_max <= w_d;
    end
  end

  assign in_ready  = w_room0;
  assign out_valid = r_v[STAGES];
  assign O         = w_o;
  assign err_cnt   = r_err_cnt;
  assign err_sum   = r_err_sum;
  assign err_max   = r_err_max;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: arithmetic reference model with scoreboard, directed
// corner cases (latency, stall, reset, clear, saturation) and randomized traffic.
module tb_approx_add_pipe;

  localparam int unsigned W      = 8;
  localparam int unsigned K      = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned ERRW   = 16;
  localparam int unsigned SERRW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [1:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      O;
  logic            clr_stats;
  logic [ERRW-1:0] err_cnt;
  logic [ERRW-1:0] err_sum;
  logic [W:0]      err_max;

  logic             s_in_valid;
  logic             s_in_ready;
  logic [W-1:0]     s_A;
  logic [W-1:0]     s_B;
  logic [1:0]       s_mode;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [W:0]       s_O;
  logic             s_clr_stats;
  logic [SERRW-1:0] s_err_cnt;
  logic [SERRW-1:0] s_err_sum;
  logic [W:0]       s_err_max;

  always #5 clk = ~clk;

  approx_add_pipe #(.W(W), .K(K), .STAGES(STAGES), .ERRW(ERRW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .O(O),
    .clr_stats(clr_stats), .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max)
  );

  approx_add_pipe #(.W(W), .K(K), .STAGES(STAGES), .ERRW(SERRW)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .A(s_A), .B(s_B),
    .mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready), .O(s_O),
    .clr_stats(s_clr_stats), .err_cnt(s_err_cnt), .err_sum(s_err_sum), .err_max(s_err_max)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W:0] o;
    logic [W:0] d;
  } exp_t;

  exp_t            q_exp[$];
  longint unsigned m_cnt, m_sum, m_max;
  logic            prev_stall;
  logic [W:0]      prev_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact high part plus injected carry, low K bits per mode.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
    longint unsigned ea, eb, mask, hi, lo, c;
    ea = a;
    eb = b;
    if (K == 0 || m == 2'd0) return (W+1)'(ea + eb);
    mask = (64'd1 << K) - 1;
    c    = (m == 2'd1) ? (((ea >> (K - 1)) & (eb >> (K - 1))) & 1) : 0;
    lo   = (m == 2'd2) ? 0 : ((ea | eb) & mask);
    hi   = (ea >> K) + (eb >> K) + c;
    return (W+1)'((hi << K) | lo);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q_exp.delete();
      m_cnt      = 0;
      m_sum      = 0;
      m_max      = 0;
      prev_stall = 1'b0;
    end else begin
      chk("err_cnt", 64'(err_cnt), m_cnt);
      chk("err_sum", 64'(err_sum), m_sum);
      chk("err_max", 64'(err_max), m_max);
      if (prev_stall) chk("O_hold", 64'(O), 64'(prev_o));
      if (out_ready) chk("in_ready_flow", 64'(in_ready), 64'd1);
      if (out_valid && q_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL no_spurious: out_valid=1 with O=0x%0h, required no result pending", O);
      end else if (out_valid && out_ready) begin
        exp_t e;
        e = q_exp.pop_front();
        chk("O", 64'(O), 64'(e.o));
        if (!clr_stats) begin
          if (e.d != 0 && m_cnt < (64'd1 << ERRW) - 1) m_cnt++;
          m_sum = m_sum + e.d;
          if (m_sum > (64'd1 << ERRW) - 1) m_sum = (64'd1 << ERRW) - 1;
          if (e.d > m_max) m_max = e.d;
        end
      end
      if (clr_stats) begin
        m_cnt = 0;
        m_sum = 0;
        m_max = 0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        longint unsigned ex, ap;
        e.o = model_sum(A, B, mode);
        ex  = longint'(A) + longint'(B);
        ap  = e.o;
        e.d = (W+1)'((ex >= ap) ? ex - ap : ap - ex);
        q_exp.push_back(e);
      end
      prev_stall = out_valid & ~out_ready;
      prev_o     = O;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    mode     = m;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = '0; out_ready = 1'b0; clr_stats = 1'b0;
    s_in_valid = 1'b0; s_A = '0; s_B = '0; s_mode = '0; s_out_ready = 1'b1; s_clr_stats = 1'b0;

    chk("model_exact", 64'(model_sum(8'hFF, 8'h01, 2'd0)), 64'h100);
    chk("model_loa",   64'(model_sum(8'h0F, 8'h01, 2'd1)), 64'h00F);
    chk("model_trunc", 64'(model_sum(8'hFF, 8'hFF, 2'd2)), 64'h1E0);
    chk("model_loanc", 64'(model_sum(8'hFF, 8'hFF, 2'd3)), 64'h1EF);
    chk("model_loa_c", 64'(model_sum(8'h08, 8'h08, 2'd1)), 64'h018);

    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_O", 64'(O), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_max", 64'(err_max), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accepted at edge n, visible after edge n+STAGES.
    out_ready = 1'b1;
    send(8'hFF, 8'h01, 2'd0);
    chk("lat_n0", 64'(out_valid), 64'd0);
    step();
    chk("lat_n1", 64'(out_valid), 64'd0);
    step();
    chk("lat_n2_valid", 64'(out_valid), 64'd1);
    chk("lat_n2_O", 64'(O), 64'h100);
    step();
    step();
    chk("exact_err_cnt", 64'(err_cnt), 64'd0);

    send(8'h0F, 8'h01, 2'd1);
    repeat (3) step();
    chk("loa_err_cnt", 64'(err_cnt), 64'd1);
    chk("loa_err_sum", 64'(err_sum), 64'd1);
    chk("loa_err_max", 64'(err_max), 64'd1);

    send(8'hFF, 8'hFF, 2'd2);
    repeat (3) step();
    chk("trunc_err_cnt", 64'(err_cnt), 64'd2);
    chk("trunc_err_sum", 64'(err_sum), 64'd31);
    chk("trunc_err_max", 64'(err_max), 64'd30);

    // Back-to-back modes 0..3 with the consumer stalled for three cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int m = 0; m < 4; m++) send(W'($urandom), W'($urandom), 2'(m));
      end
      begin
        for (int i = 0; i < 20 && !out_valid; i++) step();
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("stall_drained", 64'(q_exp.size()), 64'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 2'd1);
    send(8'h56, 8'h78, 2'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_err_sum", 64'(err_sum), 64'd0);
    chk("mid_rst_err_max", 64'(err_max), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      step();
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end

    // Clear coinciding with an erroneous transfer.
    send(8'h0F, 8'h01, 2'd1);
    repeat (3) step();
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 2'd2);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("clr_pre_cnt", 64'(err_cnt), 64'd1);
    clr_stats = 1'b1;
    out_ready = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_err_sum", 64'(err_sum), 64'd0);
    chk("clr_err_max", 64'(err_max), 64'd0);

    // Randomized traffic with back-pressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      A         = W'($urandom);
      B         = W'($urandom);
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      clr_stats = ($urandom_range(0, 99) < 3);
      step();
    end
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("rand_drained", 64'(q_exp.size()), 64'd0);

    // Full-rate streaming.
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      A        = W'($urandom);
      B        = W'($urandom);
      mode     = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("stream_drained", 64'(q_exp.size()), 64'd0);

    // Saturation on the narrow-counter instance: 20 truncate beats, d=30 each.
    s_in_valid = 1'b1;
    s_A        = 8'h0F;
    s_B        = 8'h0F;
    s_mode     = 2'd2;
    repeat (3) step();
    chk("sat_O", 64'(s_O), 64'd0);
    repeat (17) step();
    s_in_valid = 1'b0;
    repeat (5) step();
    chk("sat_err_cnt", 64'(s_err_cnt), 64'd15);
    chk("sat_err_sum", 64'(s_err_sum), 64'd15);
    chk("sat_err_max", 64'(s_err_max), 64'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_add_pipe.md
# approx_add_pipe

Parametrised, pipelined approximate unsigned adder with a per-transaction approximation mode, valid/ready handshaking on both sides, and a built-in error monitor. It generalises the fixed 8-bit approximate adders in the arithmetic library to any width, any approximated-bit count and any pipeline depth. It sits between operand producers and accumulator/MAC datapaths in the approximate-arithmetic experiments. The error monitor provides run-time error statistics for carbon/accuracy trade-off studies.

## Interface
- `W`, default 8: operand width in bits.
- `K`, default 4: number of low result bits subject to approximation; 0 ≤ K < W.
- `STAGES`, default 2: pipeline depth; W must be divisible by STAGES.
- `ERRW`, default 16: width of the statistics counters.
- `clk` input, 1 bit: clock. All state is updated on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operand beat valid.
- `in_ready` output, 1 bit: block accepts an operand beat this cycle.
- `A`, `B` input, W bits each: unsigned operands.
- `mode` input, 2 bits: approximation mode, sampled with the operands.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `O` output, W+1 bits: approximate sum, carry in the MSB.
- `clr_stats` input, 1 bit: synchronous clear of the statistics counters.
- `err_cnt` output, ERRW bits: number of delivered results with O ≠ exact sum. Saturating.
- `err_sum` output, ERRW bits: sum of |exact − O| over delivered results. Saturating.
- `err_max` output, W+1 bits: largest |exact − O| seen.

## Operation
- Modes apply to bit i < K. The upper part (bits K..W−1) is always an exact add with carry-in c.
  - 0, exact: full exact add.
  - 1, LOA: O[i] = A[i] | B[i]; c = A[K−1] & B[K−1].
  - 2, truncate: O[i] = 0; c = 0.
  - 3, LOA without carry: O[i] = A[i] | B[i]; c = 0.
- When K = 0, all modes produce the exact sum.
- Each beat carries its own mode, so a mode change takes effect on the next accepted beat with no pipeline flush.
- Pipeline:
  - Stage s adds chunk s (W/STAGES bits, LSB chunk first) using the carry registered by stage s−1.
  - Not-yet-added operand bits and already-produced sum bits are registered along the pipe.
  - The exact sum is computed in a parallel shadow pipeline with identical stage boundaries.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - The pipeline is elastic: stage s advances when stage s+1 is empty or advancing.
  - in_ready = !stage0_valid | stage0_advances. It is combinational from out_ready through the valid chain; there is no bubble when out_ready stays high.
  - O holds stable while out_valid & !out_ready.
- Error monitor, updated only on an output transfer, with d = |exact − O|:
  - err_cnt increments by 1 if d ≠ 0.
  - err_sum accumulates d.
  - err_max = max(err_max, d).
  - err_cnt and err_sum saturate at all-ones.
- clr_stats zeroes the three statistics on the next edge. If it coincides with an output transfer, the clear wins and that transfer is not counted.

## Timing
- Reset: out_valid = 0, O = 0, all stage valids = 0, err_cnt = err_sum = err_max = 0. in_ready = 1 from the first cycle after rst deasserts.
- Assertion of rst mid-operation discards all in-flight beats immediately. No partial result is ever presented.
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES.
- Throughput: 1 beat per cycle while out_ready = 1.
- Statistics reflect a transfer at edge n from cycle n+1.
- in_valid deasserted: bubbles propagate and out_valid drops correspondingly; no stale data is re-presented.
- Full pipeline with out_ready = 0: in_ready = 0; A, B and mode are ignored.

## Test plan
- W=8, K=4, STAGES=2, mode 0, A=0xFF, B=0x01 → O=0x100 two cycles after acceptance; err_cnt stays 0.
- Mode 1, A=0x0F, B=0x01 → O=0x00F; err_cnt=1, err_sum=1, err_max=1.
- Mode 2, A=0xFF, B=0xFF → O=0x1E0; d=30; err_max=30, err_sum accumulates 30.
- Back-to-back beats with modes 0,1,2,3 and out_ready held low for 3 cycles:
  - in_ready drops once both stages are full.
  - O stays stable during the stall.
  - All 4 results are delivered in order with the correct per-beat mode once ready rises.
- rst pulsed while 2 beats are in flight → out_valid=0 and stats=0 immediately; nothing is output afterwards.
- clr_stats asserted in the same cycle as an erroneous output transfer → all stats read 0 next cycle. ERRW=4, 20 mode-2 beats with A=B=0x0F → err_cnt saturates at 15.
